// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: loads a configuration flip-flop chain from a word-wide
// bitstream, MSB first, then rotates the chain once through ccff_tail ->
// ccff_head to compare read-back parity against written parity.
// chain_clk_en drives the chain's clock gate, so the chain only moves while
// bits are being shifted in or read back.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 24,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              chain_clk_en,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int BC_W = $clog2(CHAIN_LEN + 1);
  localparam int WB_W = $clog2(WORD_W + 1);

  localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(CHAIN_LEN - 1);
  localparam logic [WB_W-1:0] WORD_LAST = WB_W'(WORD_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_VERIFY,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WORD_W-1:0] sreg;
  logic [BC_W-1:0]   bit_cnt;
  logic [WB_W-1:0]   word_bit;
  logic              parity_wr;
  logic              parity_rd;

  wire last_bit  = (bit_cnt == BIT_LAST);
  wire last_word = (word_bit == WORD_LAST);

  // Next-state decode; the chain-end test takes priority over the word-end test
  // so a final partial word ends the load without another LOAD.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_LOAD;
      S_LOAD:   if (cfg_valid) state_nxt = S_SHIFT;
      S_SHIFT: begin
        if (last_bit)       state_nxt = S_VERIFY;
        else if (last_word) state_nxt = S_LOAD;
      end
      S_VERIFY: if (last_bit) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Serial bit into the chain: shift-register MSB while loading, the chain's
  // own tail while reading back (non-destructive rotate), otherwise 0.
  always_comb begin
    ccff_head = 1'b0;
    case (state)
      S_SHIFT:  ccff_head = sreg[WORD_W-1];
      S_VERIFY: ccff_head = ccff_tail;
      default:  ccff_head = 1'b0;
    endcase
  end

  // Sequencer state, registered status outputs, counters and parity.
  always_ff @(posedge prog_clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side sees the values from before this clock edge.
    if (prog_reset) begin
      state        <= S_IDLE;
      cfg_ready    <= 1'b0;
      chain_clk_en <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      bit_cnt      <= '0;
      word_bit     <= '0;
      parity_wr    <= 1'b0;
      parity_rd    <= 1'b0;
    end else begin
      state        <= state_nxt;
      cfg_ready    <= (state_nxt == S_LOAD);
      chain_clk_en <= (state_nxt == S_SHIFT) || (state_nxt == S_VERIFY);
      busy         <= (state_nxt != S_IDLE);
      done         <= (state_nxt == S_DONE);

      case (state)
        S_IDLE: begin
          if (start) begin
            bit_cnt   <= '0;
            parity_wr <= 1'b0;
            parity_rd <= 1'b0;
            error     <= 1'b0;
          end
        end

        S_LOAD: begin
          if (cfg_valid) begin
            // NOTE: the data shift register is deliberately not reset; every
            // bit is written by an accepted word before it reaches ccff_head.
            sreg     <= cfg_data;
            word_bit <= '0;
          end
        end

        S_SHIFT: begin
          sreg      <= sreg << 1;
          parity_wr <= parity_wr ^ sreg[WORD_W-1];
          word_bit  <= word_bit + WB_W'(1);
          if (last_bit) bit_cnt <= '0;
          else          bit_cnt <= bit_cnt + BC_W'(1);
        end

        S_VERIFY: begin
          parity_rd <= parity_rd ^ ccff_tail;
          if (last_bit) begin
            bit_cnt <= '0;
            error   <= ((parity_rd ^ ccff_tail) != parity_wr);
          end else begin
            bit_cnt <= bit_cnt + BC_W'(1);
          end
        end

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader: two instances (24/8 and 20/8), each
// driving a behavioural shift chain clocked on prog_clk and gated by
// chain_clk_en. Cycle 1 is the cycle in which start is high.
module tb_ccff_chain_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic prog_reset;

  // 24-bit chain, 8-bit words
  logic        start_a, valid_a, ready_a, head_a, tail_a, en_a, busy_a, done_a, err_a;
  logic        flip_a;
  logic [7:0]  data_a;
  logic [23:0] chain_a = '0;

  // 20-bit chain, 8-bit words (partial final word)
  logic        start_b, valid_b, ready_b, head_b, tail_b, en_b, busy_b, done_b, err_b;
  logic [7:0]  data_b;
  logic [19:0] chain_b = '0;

  int total = 0;
  int bad   = 0;

  int lat, en_n, viol, rdy_n, seen;

  ccff_chain_loader #(.CHAIN_LEN(24), .WORD_W(8)) dut_a (
    .prog_clk    (clk),
    .prog_reset  (prog_reset),
    .start       (start_a),
    .cfg_data    (data_a),
    .cfg_valid   (valid_a),
    .cfg_ready   (ready_a),
    .ccff_head   (head_a),
    .ccff_tail   (tail_a),
    .chain_clk_en(en_a),
    .busy        (busy_a),
    .done        (done_a),
    .error       (err_a)
  );

  ccff_chain_loader #(.CHAIN_LEN(20), .WORD_W(8)) dut_b (
    .prog_clk    (clk),
    .prog_reset  (prog_reset),
    .start       (start_b),
    .cfg_data    (data_b),
    .cfg_valid   (valid_b),
    .cfg_ready   (ready_b),
    .ccff_head   (head_b),
    .ccff_tail   (tail_b),
    .chain_clk_en(en_b),
    .busy        (busy_b),
    .done        (done_b),
    .error       (err_b)
  );

  // flip_a corrupts the bit the loader reads back, modelling a bad chain cell.
  assign tail_a = chain_a[23] ^ flip_a;
  assign tail_b = chain_b[19];

  // Behavioural chain A: shifts toward the tail on enabled edges.
  always @(posedge clk) if (en_a) chain_a <= {chain_a[22:0], head_a};

  // Behavioural chain B.
  always @(posedge clk) if (en_b) chain_b <= {chain_b[18:0], head_b};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One sequence on instance A, called just after a negedge. Options (0 = off):
  // stall_n LOAD cycles with cfg_valid low before the second word, tail flip on
  // enabled cycle flip_at, start pulse on enabled cycle start_at, reset on
  // enabled cycle rst_at. viol counts LOAD cycles with the chain enabled or
  // head high, and LOAD cycles after the last word.
  task automatic run_a(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                       input int stall_n, input int flip_at, input int start_at,
                       input int rst_at, output int lat_o, output int en_o, output int viol_o);
    logic [7:0] words [3];
    int widx, cyc, stall_left;
    words[0] = w0; words[1] = w1; words[2] = w2;
    widx = 0; cyc = 1; stall_left = stall_n;
    lat_o = 0; en_o = 0; viol_o = 0;
    start_a = 1'b1;
    while (cyc < 300) begin
      @(negedge clk);
      cyc++;
      start_a = 1'b0;
      valid_a = 1'b0;
      flip_a  = 1'b0;
      if (done_a) begin
        lat_o = cyc;
        break;
      end
      if (ready_a && (en_a || head_a)) viol_o++;
      if (en_a) begin
        en_o++;
        if (en_o == start_at) start_a = 1'b1;
        if (en_o == flip_at)  flip_a  = 1'b1;
        if (en_o == rst_at) begin
          prog_reset = 1'b1;
          break;
        end
      end
      if (ready_a) begin
        if (widx == 1 && stall_left > 0) begin
          stall_left--;
        end else if (widx < 3) begin
          valid_a = 1'b1;
          data_a  = words[widx];
          widx++;
        end else begin
          viol_o++;
        end
      end
    end
  endtask

  // One sequence on instance B; counts enabled and ready cycles.
  task automatic run_b(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                       output int lat_o, output int en_o, output int rdy_o);
    logic [7:0] words [3];
    int widx, cyc;
    words[0] = w0; words[1] = w1; words[2] = w2;
    widx = 0; cyc = 1;
    lat_o = 0; en_o = 0; rdy_o = 0;
    start_b = 1'b1;
    while (cyc < 300) begin
      @(negedge clk);
      cyc++;
      start_b = 1'b0;
      valid_b = 1'b0;
      if (done_b) begin
        lat_o = cyc;
        break;
      end
      if (en_b) en_o++;
      if (ready_b) begin
        rdy_o++;
        if (widx < 3) begin
          valid_b = 1'b1;
          data_b  = words[widx];
          widx++;
        end
      end
    end
  endtask

  initial begin
    prog_reset = 1'b1;
    start_a = 1'b0; valid_a = 1'b0; data_a = '0; flip_a = 1'b0;
    start_b = 1'b0; valid_b = 1'b0; data_b = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_outs_a", {26'd0, ready_a, head_a, en_a, busy_a, done_a, err_a}, 32'd0);
    check("reset_outs_b", {26'd0, ready_b, head_b, en_b, busy_b, done_b, err_b}, 32'd0);
    prog_reset = 1'b0;
    @(negedge clk);
    check("idle_outs_a", {26'd0, ready_a, head_a, en_a, busy_a, done_a, err_a}, 32'd0);

    // 1: back-to-back words
    run_a(8'hA5, 8'h3C, 8'hF0, 0, 0, 0, 0, lat, en_n, viol);
    check("t1_latency", lat, 53);
    check("t1_en_cycles", en_n, 48);
    check("t1_load_viol", viol, 0);
    check("t1_chain", {8'd0, chain_a}, 32'h00A53CF0);
    check("t1_error", {31'd0, err_a}, 32'd0);
    @(negedge clk);
    check("t1_done_pulse", {30'd0, done_a, busy_a}, 32'd0);

    // 2: five-cycle stall before the second word
    run_a(8'hA5, 8'h3C, 8'hF0, 5, 0, 0, 0, lat, en_n, viol);
    check("t2_latency", lat, 58);
    check("t2_en_cycles", en_n, 48);
    check("t2_load_viol", viol, 0);
    check("t2_chain", {8'd0, chain_a}, 32'h00A53CF0);
    check("t2_error", {31'd0, err_a}, 32'd0);
    @(negedge clk);

    // 3: 20-bit chain, top nibble of the last word only
    run_b(8'hFF, 8'h00, 8'h9F, lat, en_n, rdy_n);
    check("t3_latency", lat, 45);
    check("t3_en_cycles", en_n, 40);
    check("t3_ready_cycles", rdy_n, 3);
    check("t3_chain", {12'd0, chain_b}, 32'h000FF009);
    check("t3_error", {31'd0, err_b}, 32'd0);
    @(negedge clk);

    // 4: corrupted read-back bit on the 6th VERIFY cycle
    run_a(8'h12, 8'h34, 8'h56, 0, 30, 0, 0, lat, en_n, viol);
    check("t4_latency", lat, 53);
    check("t4_error", {31'd0, err_a}, 32'd1);
    repeat (3) @(negedge clk);
    check("t4_error_sticky", {31'd0, err_a}, 32'd1);

    // 6: start pulsed mid-SHIFT is ignored; the new start clears the old error
    run_a(8'hA5, 8'h3C, 8'hF0, 0, 0, 5, 0, lat, en_n, viol);
    check("t6_latency", lat, 53);
    check("t6_en_cycles", en_n, 48);
    check("t6_chain", {8'd0, chain_a}, 32'h00A53CF0);
    check("t6_error_cleared", {31'd0, err_a}, 32'd0);
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy_a || done_a) seen++;
    end
    check("t6_no_restart", seen, 0);

    // 5: reset during SHIFT, then a clean sequence
    run_a(8'hC3, 8'h5A, 8'h0F, 0, 0, 0, 10, lat, en_n, viol);
    check("t5_no_done_before_reset", lat, 0);
    @(negedge clk);
    prog_reset = 1'b0;
    check("t5_reset_outs", {26'd0, ready_a, head_a, en_a, busy_a, done_a, err_a}, 32'd0);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (busy_a || done_a) seen++;
    end
    check("t5_idle_after_reset", seen, 0);
    run_a(8'hA5, 8'h3C, 8'hF0, 0, 0, 0, 0, lat, en_n, viol);
    check("t5_rerun_latency", lat, 53);
    check("t5_rerun_chain", {8'd0, chain_a}, 32'h00A53CF0);
    check("t5_rerun_error", {31'd0, err_a}, 32'd0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
